// File: rtl/mvm_pkg.sv
// Shared FSM state type and sizing helpers for the matrix-vector multiply engine.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Index width that stays legal (>= 1 bit) for a single-entry range
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int run_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/mvm_pe.sv
// One systolic multiply-accumulate stage: registers enable and B for the next
// stage, and accumulates A*B into an ACC_WIDTH register that wraps on overflow.
module mvm_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  en_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         a_ext_s;
  logic [PW-1:0]         b_ext_s;
  logic [PW-1:0]         prod_s;
  logic [ACC_WIDTH-1:0]  prod_ext_s;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  en_q;
  logic [DATA_WIDTH-1:0] b_q;

  // Full-width product, then sign- or zero-extension to the accumulator width
  always_comb begin
    if (SIGNED != 0) begin
      a_ext_s    = PW'($signed(a_i));
      b_ext_s    = PW'($signed(b_i));
      prod_s     = a_ext_s * b_ext_s;
      prod_ext_s = ACC_WIDTH'($signed(prod_s));
    end else begin
      a_ext_s    = PW'(a_i);
      b_ext_s    = PW'(b_i);
      prod_s     = a_ext_s * b_ext_s;
      prod_ext_s = ACC_WIDTH'(prod_s);
    end
  end

  // Accumulator next state: clear for a new operation, accumulate when enabled
  always_comb begin
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Skew registers and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      en_q  <= en_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign en_o  = en_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: per-row A FIFOs and a B FIFO feed a skewed
// chain of MAC stages; results drain one row per cycle over valid/ready.
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int SIGNED     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_wr_valid,
  input  logic [idx_w(ROWS)-1:0]  a_wr_row,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  output logic                    a_wr_ready,
  input  logic                    b_wr_valid,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  output logic                    b_wr_ready,
  input  logic                    start,
  output logic                    start_err,
  output logic                    busy,
  output logic                    c_valid,
  output logic [idx_w(ROWS)-1:0]  c_index,
  output logic [ACC_WIDTH-1:0]    c_data,
  input  logic                    c_ready,
  output logic                    done
);

  localparam int IW      = idx_w(ROWS);
  localparam int PW      = idx_w(COLS);
  localparam int CW      = $clog2(COLS + 1);
  localparam int KW      = $clog2(ROWS + COLS);
  localparam int RUN_LEN = run_len(ROWS, COLS);

  state_e               state_q;
  logic [KW-1:0]        k_q;
  logic                 start_err_q, busy_q, c_valid_q, done_q;
  logic [IW-1:0]        c_index_q;

  logic [DATA_WIDTH-1:0] a_mem_q [ROWS][COLS];
  logic [PW-1:0]         a_wp_q  [ROWS];
  logic [PW-1:0]         a_rp_q  [ROWS];
  logic [CW-1:0]         a_cnt_q [ROWS];
  logic [DATA_WIDTH-1:0] b_mem_q [COLS];
  logic [PW-1:0]         b_wp_q, b_rp_q;
  logic [CW-1:0]         b_cnt_q;

  logic [ROWS-1:0]       a_push_s, pe_en_s, pe_en_out_s;
  logic                  b_push_s, all_full_s, go_s;
  logic [DATA_WIDTH-1:0] pe_a_s [ROWS];
  logic [DATA_WIDTH-1:0] pe_b_s [ROWS];
  logic [DATA_WIDTH-1:0] pe_b_out_s [ROWS];
  logic [ACC_WIDTH-1:0]  acc_s [ROWS];
  logic                  chain_unused_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(COLS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Write acceptance, start qualification and PE feed selection
  always_comb begin
    all_full_s = (b_cnt_q == CW'(COLS));
    a_wr_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      all_full_s  = all_full_s && (a_cnt_q[r] == CW'(COLS));
      a_push_s[r] = (state_q == IDLE) && a_wr_valid && (a_wr_row == IW'(r)) &&
                    (a_cnt_q[r] != CW'(COLS));
      a_wr_ready  = a_wr_ready || ((state_q == IDLE) && (a_wr_row == IW'(r)) &&
                    (a_cnt_q[r] != CW'(COLS)));
      pe_a_s[r]   = a_mem_q[r][a_rp_q[r]];
    end
    b_wr_ready = (state_q == IDLE) && (b_cnt_q != CW'(COLS));
    b_push_s   = b_wr_valid && b_wr_ready;
    go_s       = (state_q == IDLE) && start && all_full_s;
    pe_en_s[0] = (state_q == RUN) && (k_q < KW'(COLS));
    pe_b_s[0]  = b_mem_q[b_rp_q];
    for (int r = 1; r < ROWS; r++) begin
      pe_en_s[r] = pe_en_out_s[r-1];
      pe_b_s[r]  = pe_b_out_s[r-1];
    end
  end

  // FIFO storage (contents need no reset; occupancy lives in the counters)
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (a_push_s[r]) a_mem_q[r][a_wp_q[r]] <= a_wr_data;
    end
    if (b_push_s) b_mem_q[b_wp_q] <= b_wr_data;
  end

  // FIFO pointers and occupancy; pushes only occur in IDLE, pops only in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        a_wp_q[r]  <= '0;
        a_rp_q[r]  <= '0;
        a_cnt_q[r] <= '0;
      end
      b_wp_q  <= '0;
      b_rp_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (a_push_s[r]) begin
          a_wp_q[r]  <= ptr_inc(a_wp_q[r]);
          a_cnt_q[r] <= a_cnt_q[r] + CW'(1);
        end else if (pe_en_s[r]) begin
          a_rp_q[r]  <= ptr_inc(a_rp_q[r]);
          a_cnt_q[r] <= a_cnt_q[r] - CW'(1);
        end
      end
      if (b_push_s) begin
        b_wp_q  <= ptr_inc(b_wp_q);
        b_cnt_q <= b_cnt_q + CW'(1);
      end else if (pe_en_s[0]) begin
        b_rp_q  <= ptr_inc(b_rp_q);
        b_cnt_q <= b_cnt_q - CW'(1);
      end
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      start_err_q <= 1'b0;
      busy_q      <= 1'b0;
      c_valid_q   <= 1'b0;
      c_index_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      start_err_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_s) begin
            state_q <= RUN;
            k_q     <= '0;
            busy_q  <= 1'b1;
          end else if (start) begin
            start_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (k_q == KW'(RUN_LEN - 1)) begin
            state_q   <= DRAIN;
            k_q       <= '0;
            c_valid_q <= 1'b1;
            c_index_q <= '0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DRAIN: begin
          if (c_ready) begin
            if (c_index_q == IW'(ROWS - 1)) begin
              state_q   <= IDLE;
              c_valid_q <= 1'b0;
              c_index_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              c_index_q <= c_index_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result mux: accumulators are frozen in DRAIN, so data is stable under stall
  always_comb begin
    if (c_valid_q) begin
      c_data = acc_s[c_index_q];
    end else begin
      c_data = '0;
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_pe
    mvm_pe #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED)
    ) u_pe (
      .clk  (clk),
      .rst  (rst),
      .clr_i(go_s),
      .en_i (pe_en_s[g]),
      .a_i  (pe_a_s[g]),
      .b_i  (pe_b_s[g]),
      .en_o (pe_en_out_s[g]),
      .b_o  (pe_b_out_s[g]),
      .acc_o(acc_s[g])
    );
  end

  assign chain_unused_s = ^{pe_en_out_s[ROWS-1], pe_b_out_s[ROWS-1]};

  assign start_err = start_err_q;
  assign busy      = busy_q;
  assign c_valid   = c_valid_q;
  assign c_index   = c_index_q;
  assign done      = done_q;

endmodule
